// File: rtl/pll_lock_sequencer_pkg.sv
// rtl/pll_lock_sequencer_pkg.sv - state codes and helpers shared by the PLL lock sequencer and its bench
package pll_lock_sequencer_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    QUALIFY   = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_synchroniser.sv
// rtl/lock_synchroniser.sv - multi-flop synchroniser for a single asynchronous status flag
module lock_synchroniser #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - qualifies PLL lock, sequences system reset release, tracks loss-of-lock events
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int LOCK_QUAL_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES  = 16,
  parameter int GLITCH_FILT      = 4,
  parameter int LOSS_CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_lock,
  input  logic                   clear_loss_cnt,
  output logic                   sys_rst_n,
  output logic                   ready,
  output logic [SEQ_STATE_W-1:0] seq_state,
  output logic                   lock_lost,
  output logic [LOSS_CNT_W-1:0]  loss_count
);

  localparam int CNT_W  = $clog2(max_int(LOCK_QUAL_CYCLES, RST_HOLD_CYCLES) + 1);
  localparam int FILT_W = $clog2(GLITCH_FILT + 1);

  localparam logic [CNT_W-1:0]      QUAL_LAST = CNT_W'(LOCK_QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [FILT_W-1:0]     FILT_LAST = FILT_W'(GLITCH_FILT - 1);
  localparam logic [FILT_W-1:0]     FILT_ONE  = FILT_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE  = LOSS_CNT_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX  = '1;

  logic                  lock_s;
  seq_state_e            state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [FILT_W-1:0]     filt_q, filt_nxt;
  logic [LOSS_CNT_W-1:0] loss_nxt;
  logic                  loss_event;

  lock_synchroniser #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk      (clk),
    .rst_n    (reset_n),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      filt_q     <= '0;
      sys_rst_n  <= 1'b0;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      loss_count <= '0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      filt_q     <= filt_nxt;
      sys_rst_n  <= (state_nxt == RELEASE) || (state_nxt == RUN);
      ready      <= (state_nxt == RUN);
      lock_lost  <= loss_event;
      loss_count <= loss_nxt;
    end
  end

  // One counter is reused for qualification, reset hold and LOST dwell; it restarts on every state change.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    filt_nxt   = '0;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) begin
          state_nxt = QUALIFY;
        end
      end
      QUALIFY: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == QUAL_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      RELEASE, RUN: begin
        if (!lock_s && (filt_q == FILT_LAST)) begin
          state_nxt  = LOST;
          cnt_nxt    = '0;
          loss_event = 1'b1;
        end else begin
          filt_nxt = lock_s ? '0 : (filt_q + FILT_ONE);
          if (state_q == RELEASE) begin
            if (cnt_q == HOLD_LAST) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_q + CNT_ONE;
            end
          end
        end
      end
      LOST: begin
        if (cnt_q == HOLD_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A clear coinciding with a loss keeps that loss, so the count restarts at one.
  always_comb begin
    loss_nxt = loss_count;
    if (clear_loss_cnt) begin
      loss_nxt = loss_event ? LOSS_ONE : '0;
    end else if (loss_event && (loss_count != LOSS_MAX)) begin
      loss_nxt = loss_count + LOSS_ONE;
    end
  end

  assign seq_state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;
  import pll_lock_sequencer_pkg::*;

  localparam int S_RST = 0;
  localparam int S_RDY = 1;
  localparam int S_ST  = 2;
  localparam int S_LL  = 3;
  localparam int S_LC  = 4;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string tag;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       pll_lock;
  logic       clear_loss_cnt;
  logic       sys_rst_n;
  logic       ready;
  logic [2:0] seq_state;
  logic       lock_lost;
  logic [1:0] loss_count;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  pll_lock_sequencer #(
    .SYNC_STAGES      (2),
    .LOCK_QUAL_CYCLES (8),
    .RST_HOLD_CYCLES  (4),
    .GLITCH_FILT      (3),
    .LOSS_CNT_W       (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_lock       (pll_lock),
    .clear_loss_cnt (clear_loss_cnt),
    .sys_rst_n      (sys_rst_n),
    .ready          (ready),
    .seq_state      (seq_state),
    .lock_lost      (lock_lost),
    .loss_count     (loss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int actual(input int sel);
    case (sel)
      S_RST:   return int'(sys_rst_n);
      S_RDY:   return int'(ready);
      S_ST:    return int'(seq_state);
      S_LL:    return int'(lock_lost);
      default: return int'(loss_count);
    endcase
  endfunction

  function automatic void expect_at(input int c, input int sel, input int val, input string tag);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, actual(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      step(1);
      guard++;
    end
    while (sb.size() > 0) begin
      check({sb[0].tag, "_timeout"}, -1, sb[0].val);
      sb.delete(0);
    end
  endtask

  // tw: first WAIT_LOCK cycle in which the synchronised lock is already high.
  function automatic void push_relock(input int tw);
    expect_at(tw,      S_ST,  int'(WAIT_LOCK), "wait_state");
    expect_at(tw + 1,  S_ST,  int'(QUALIFY),   "qual_enter");
    expect_at(tw + 8,  S_ST,  int'(QUALIFY),   "qual_last");
    expect_at(tw + 8,  S_RST, 0,               "sysrst_held");
    expect_at(tw + 9,  S_RST, 1,               "sysrst_release");
    expect_at(tw + 9,  S_ST,  int'(RELEASE),   "release_enter");
    expect_at(tw + 12, S_ST,  int'(RELEASE),   "release_last");
    expect_at(tw + 12, S_RDY, 0,               "ready_held");
    expect_at(tw + 13, S_RDY, 1,               "ready_set");
    expect_at(tw + 13, S_ST,  int'(RUN),       "run_enter");
  endfunction

  function automatic void push_clean_start(input int t0);
    push_relock(t0 + 2);
    for (int k = 0; k <= 15; k++) expect_at(t0 + k, S_LL, 0, "t1_no_lost");
    expect_at(t0 + 15, S_LC, 0, "t1_loss_cnt");
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_sysrst"}, int'(sys_rst_n), 0);
    check({tag, "_ready"}, int'(ready), 0);
    check({tag, "_state"}, int'(seq_state), int'(WAIT_LOCK));
    check({tag, "_lost"}, int'(lock_lost), 0);
    check({tag, "_losscnt"}, int'(loss_count), 0);
  endtask

  // Called from RUN: lock drops, LOST follows after the filter, then a full requalification.
  task automatic do_loss(input int low_cyc, input bit clr, input int exp_cnt);
    int t1;
    t1 = cyc;
    pll_lock = 1'b0;
    for (int k = 0; k <= 4; k++) expect_at(t1 + k, S_ST, int'(RUN), "loss_filtering");
    expect_at(t1 + 4, S_RST, 1,          "loss_pre_sysrst");
    expect_at(t1 + 4, S_LL,  0,          "loss_pre_pulse");
    expect_at(t1 + 5, S_ST,  int'(LOST), "lost_enter");
    expect_at(t1 + 5, S_RST, 0,          "lost_sysrst");
    expect_at(t1 + 5, S_RDY, 0,          "lost_ready");
    expect_at(t1 + 5, S_LL,  1,          "lost_pulse");
    expect_at(t1 + 6, S_LL,  0,          "lost_pulse_end");
    expect_at(t1 + 5, S_LC,  exp_cnt,    "loss_cnt");
    for (int k = 6; k <= 8; k++) expect_at(t1 + k, S_ST, int'(LOST), "lost_dwell");
    push_relock(t1 + 9);
    expect_at(t1 + 22, S_LC, exp_cnt, "loss_cnt_hold");
    for (int k = 1; k <= 23; k++) begin
      step(1);
      if (cyc - t1 == low_cyc) pll_lock = 1'b1;
      if (clr && (cyc - t1 == 4)) clear_loss_cnt = 1'b1;
      if (cyc - t1 == 5) clear_loss_cnt = 1'b0;
    end
    drain();
  endtask

  initial begin
    int t0;
    int t1;
    reset_n = 1'b0;
    pll_lock = 1'b0;
    clear_loss_cnt = 1'b0;
    step(3);
    check_reset_vals("reset");
    reset_n = 1'b1;
    step(2);

    // T1 clean start
    t0 = cyc;
    pll_lock = 1'b1;
    push_clean_start(t0);
    step(16);
    drain();

    // T3 short glitch ignored, three-cycle drop is a loss
    t0 = cyc;
    pll_lock = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      expect_at(t0 + k, S_ST,  int'(RUN), "glitch_state");
      expect_at(t0 + k, S_RDY, 1,         "glitch_ready");
    end
    step(2);
    pll_lock = 1'b1;
    step(8);
    drain();
    do_loss(3, 1'b0, 1);

    // T4 saturation, then clear coincident with a loss, then clear alone
    for (int i = 0; i < 5; i++) do_loss(3, 1'b0, (i == 0) ? 2 : 3);
    do_loss(3, 1'b1, 1);
    t0 = cyc;
    expect_at(t0,     S_LC, 1, "clr_before");
    expect_at(t0 + 1, S_LC, 0, "clr_alone");
    clear_loss_cnt = 1'b1;
    step(1);
    clear_loss_cnt = 1'b0;
    step(2);
    drain();

    // T6 lock returns one cycle into LOST; dwell still completes
    do_loss(6, 1'b0, 1);

    // T5 async reset while in RELEASE
    t1 = cyc;
    pll_lock = 1'b0;
    expect_at(t1 + 5, S_ST, int'(LOST), "t5_lost");
    expect_at(t1 + 5, S_LL, 1,          "t5_lost_pulse");
    step(10);
    t0 = cyc;
    pll_lock = 1'b1;
    expect_at(t0 + 11, S_ST,  int'(RELEASE), "t5_release");
    expect_at(t0 + 11, S_RST, 1,             "t5_sysrst");
    expect_at(t0 + 11, S_LC,  2,             "t5_losscnt");
    step(12);
    drain();
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    step(1);
    reset_n = 1'b1;
    t0 = cyc;
    push_clean_start(t0);
    step(16);
    drain();

    // T2 lock chatter during qualification
    pll_lock = 1'b0;
    step(1);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    t0 = cyc;
    pll_lock = 1'b1;
    for (int k = 3; k <= 7; k++) expect_at(t0 + k, S_ST, int'(QUALIFY), "chatter_qual");
    push_relock(t0 + 8);
    expect_at(t0 + 8, S_LC, 0, "chatter_losscnt");
    expect_at(t0 + 8, S_LL, 0, "chatter_no_lost");
    expect_at(t0 + 21, S_LC, 0, "chatter_losscnt_end");
    step(5);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(16);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
